// File: rtl/fragment_mem_responder_pkg.sv
// Shared types and widths for the fragment memory responder.
package fragment_mem_pkg;

  localparam int unsigned FRAG_ADDR_W = 24;
  localparam int unsigned FRAG_DATA_W = 32;
  localparam int unsigned CORE_ID_W   = 7;
  localparam int unsigned WORD_SHIFT  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    RD_HOLD = 3'd3,
    RD_REL  = 3'd4,
    WR_CMD  = 3'd5,
    WR_REL  = 3'd6
  } resp_state_t;

endpackage

// File: rtl/fragment_mem_responder.sv
// Turns held fragment texture-read / pixel-write requests into single-word Avalon-MM accesses.
// Optional watchdog enabled by defining FRAG_RESP_TIMEOUT_EN (adds timeout_err).
module fragment_mem_responder
  import fragment_mem_pkg::*;
#(
  parameter int unsigned              AVM_ADDR_W     = 32,
  parameter logic [AVM_ADDR_W-1:0]    BASE_ADDR      = '0,
  parameter int unsigned              TIMEOUT_CYCLES = 1024,
  parameter logic [FRAG_DATA_W-1:0]   ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   texture_req,
  input  logic [FRAG_ADDR_W-1:0] texture_addr,
  input  logic [CORE_ID_W-1:0]   texture_core_id,
  output logic                   texture_valid,
  output logic [FRAG_DATA_W-1:0] texture_data,
  input  logic                   texture_read_done,
  input  logic                   write_req,
  input  logic [FRAG_ADDR_W-1:0] write_addr,
  input  logic [FRAG_DATA_W-1:0] write_data,
  input  logic [CORE_ID_W-1:0]   write_core_id,
  output logic                   write_valid,
  output logic                   write_done,
  output logic [AVM_ADDR_W-1:0]  avm_address,
  output logic                   avm_read,
  output logic                   avm_write,
  output logic [FRAG_DATA_W-1:0] avm_writedata,
  output logic [3:0]             avm_byteenable,
  input  logic                   avm_waitrequest,
  input  logic [FRAG_DATA_W-1:0] avm_readdata,
  input  logic                   avm_readdatavalid,
  output logic                   busy,
`ifdef FRAG_RESP_TIMEOUT_EN
  output logic                   timeout_err,
`endif
  output logic [CORE_ID_W-1:0]   last_core_id
);

  resp_state_t            state_q, state_d;
  logic [FRAG_ADDR_W-1:0] addr_q, addr_d;
  logic [FRAG_DATA_W-1:0] wdata_q, wdata_d;
  logic [FRAG_DATA_W-1:0] tdata_q, tdata_d;
  logic [CORE_ID_W-1:0]   core_q, core_d;
  logic                   last_wr_q, last_wr_d;
  logic                   wpulse_q, wpulse_d;
  logic                   early_q, early_d;
  logic                   pick_rd;
  logic [AVM_ADDR_W-1:0]  byte_off;

`ifdef FRAG_RESP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 2;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             counting, timed_out;
`else
  // Watchdog parameters stay on the interface so both builds share one parameter list.
  if (TIMEOUT_CYCLES == 0 || ERR_DATA == '0) begin : g_timeout_cfg_unused
  end
`endif

  assign byte_off = AVM_ADDR_W'({addr_q, {WORD_SHIFT{1'b0}}});

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tdata_d   = tdata_q;
    core_d    = core_q;
    last_wr_d = last_wr_q;
    wpulse_d  = 1'b0;
    early_d   = early_q;
    pick_rd   = texture_req && (!write_req || last_wr_q);
    unique case (state_q)
      IDLE: begin
        early_d = 1'b0;
        if (pick_rd) begin
          state_d   = RD_CMD;
          addr_d    = texture_addr;
          core_d    = texture_core_id;
          last_wr_d = 1'b0;
        end else if (write_req) begin
          state_d   = WR_CMD;
          addr_d    = write_addr;
          wdata_d   = write_data;
          core_d    = write_core_id;
          last_wr_d = 1'b1;
        end
      end
      RD_CMD: begin
        if (!avm_waitrequest) begin
          state_d = RD_DATA;
          // Data arriving alongside command acceptance is parked and consumed in RD_DATA.
          if (avm_readdatavalid) begin
            tdata_d = avm_readdata;
            early_d = 1'b1;
          end
        end
      end
      RD_DATA: begin
        if (early_q) begin
          state_d = RD_HOLD;
        end else if (avm_readdatavalid) begin
          tdata_d = avm_readdata;
          state_d = RD_HOLD;
        end
      end
      RD_HOLD: if (texture_read_done) state_d = RD_REL;
      RD_REL:  if (!texture_req) state_d = IDLE;
      WR_CMD: begin
        if (!avm_waitrequest) begin
          wpulse_d = 1'b1;
          state_d  = WR_REL;
        end
      end
      WR_REL:  if (!write_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef FRAG_RESP_TIMEOUT_EN
    counting  = (state_q == RD_CMD) || (state_q == RD_DATA) || (state_q == WR_CMD);
    cnt_d     = counting ? cnt_q + 1'b1 : '0;
    timed_out = counting && (state_d == state_q) &&
                (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
    terr_d    = terr_q | timed_out;
    if (timed_out) begin
      if (state_q == WR_CMD) begin
        wpulse_d = 1'b1;
        state_d  = WR_REL;
      end else begin
        tdata_d = ERR_DATA;
        state_d = RD_HOLD;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      tdata_q   <= '0;
      core_q    <= '0;
      last_wr_q <= 1'b1;
      wpulse_q  <= 1'b0;
      early_q   <= 1'b0;
`ifdef FRAG_RESP_TIMEOUT_EN
      cnt_q     <= '0;
      terr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tdata_q   <= tdata_d;
      core_q    <= core_d;
      last_wr_q <= last_wr_d;
      wpulse_q  <= wpulse_d;
      early_q   <= early_d;
`ifdef FRAG_RESP_TIMEOUT_EN
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
`endif
    end
  end

  assign avm_read       = (state_q == RD_CMD);
  assign avm_write      = (state_q == WR_CMD);
  assign avm_address    = (avm_read || avm_write) ? BASE_ADDR + byte_off : '0;
  assign avm_writedata  = avm_write ? wdata_q : '0;
  assign avm_byteenable = 4'hF;
  assign texture_valid  = (state_q == RD_HOLD);
  assign texture_data   = tdata_q;
  assign write_valid    = wpulse_q;
  assign write_done     = wpulse_q;
  assign busy           = (state_q != IDLE);
  assign last_core_id   = core_q;
`ifdef FRAG_RESP_TIMEOUT_EN
  assign timeout_err    = terr_q;
`endif

endmodule

// File: doc/fragment_mem_responder.md
Name: fragment_mem_responder

Overview:
Memory-side responder for the unified fragment texture-read and pixel-write channels produced by the 4-to-1 fragment arbiter. Converts each held request into one single-word access on an Avalon-MM-style master port. Returns texture data or write completion using the same hold/acknowledge handshake the fragment cores use. Sits between the fragment arbiter and the system interconnect or SDRAM.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address added to every request.
AVM_ADDR_W, 32, width of the memory-side byte address.
TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature.
ERR_DATA, 32'hDEAD_BEEF, texture data returned on timeout; used only with the optional feature.

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
texture_req  in  1  texture read request, held by the requester
texture_addr  in  24  word address
texture_core_id  in  7  requester tag, captured for debug
texture_valid  out  1  read data valid, held until texture_read_done
texture_data  out  32  read data
texture_read_done  in  1  requester consumed the data
write_req  in  1  write request, held by the requester
write_addr  in  24  word address
write_data  in  32  write data
write_core_id  in  7  requester tag
write_valid  out  1  write accepted (1-cycle pulse)
write_done  out  1  write complete (1-cycle pulse, coincident with write_valid)
avm_address  out  AVM_ADDR_W  byte address = BASE_ADDR + {addr,2'b00}
avm_read  out  1  read command
avm_write  out  1  write command
avm_writedata  out  32  write data
avm_byteenable  out  4  always 4'hF
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data strobe
busy  out  1  FSM not in IDLE
last_core_id  out  7  core_id of the most recently accepted request

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. All outputs 0 except avm_byteenable=4'hF. last_pref=write, so texture wins the first tie. A request in flight is abandoned and never completed. Requesters see no valid and must re-request.
- IDLE: if only one of texture_req or write_req is high, serve it. If both are high, serve the class not served last (alternating). On acceptance, register addr, data and core_id, then go to RD_CMD or WR_CMD. last_core_id updates on acceptance.
- RD_CMD: avm_read=1 with the registered address. Stay while avm_waitrequest=1. When the command is accepted (read & !waitrequest), go to RD_DATA.
- RD_DATA: on avm_readdatavalid, capture avm_readdata into texture_data and go to RD_HOLD. readdatavalid in the same cycle as command acceptance is legal and is captured the next cycle. The slave may return data no earlier than that.
- RD_HOLD: texture_valid=1 and texture_data stable. On texture_read_done=1, drop texture_valid the next cycle and go to RD_REL.
- RD_REL: wait for texture_req=0, then return to IDLE. This prevents serving the same held request twice.
- WR_CMD: avm_write=1 with address and data. When the command is accepted, pulse write_valid=write_done=1 for exactly one cycle (the cycle after acceptance), then go to WR_REL.
- WR_REL: wait for write_req=0, then return to IDLE.
- Minimum latency, zero-wait slave: read request to texture_valid = 3 cycles; write request to write_done = 2 cycles.
- Request inputs are sampled only in IDLE. Address or data changes during service are ignored.
- Exactly one avm command per accepted request. avm_read and avm_write are never asserted together.
- Addresses wrap modulo 2^AVM_ADDR_W; no overflow detection.
- Back-to-back requests of the same class are allowed with one IDLE cycle between them.

Optional Feature:
FRAG_RESP_TIMEOUT_EN
- Defined:
  - A cycle counter runs in RD_CMD, RD_DATA and WR_CMD.
  - At TIMEOUT_CYCLES, a read completes with texture_data=ERR_DATA via the normal RD_HOLD path.
  - A write completes with the normal write_valid/write_done pulse.
  - avm_read/avm_write deassert immediately, and late readdatavalid is ignored until the next RD_DATA.
  - Adds output timeout_err (1 bit, sticky, cleared only by rst).
- Undefined: no counter and no timeout_err port; the FSM waits indefinitely.

Decomposition:
- Package fragment_mem_pkg holds:
  - the resp_state_t enum (IDLE, RD_CMD, RD_DATA, RD_HOLD, RD_REL, WR_CMD, WR_REL);
  - FRAG_ADDR_W=24, FRAG_DATA_W=32, CORE_ID_W=7;
  - the word-to-byte shift constant.
- No sub-module needed. The optional watchdog counter stays inline.

Test Plan:
- Zero-wait read: texture_req, addr=24'h000010, readdata=32'hA5A5_0001 → avm_address=32'h40, texture_valid rises 3 cycles after req, data matches; held until read_done, no second avm_read while req is still high.
- Stalled write: write_req, addr=24'h1, data=32'h1234_5678, waitrequest=1 for 5 cycles → avm_write held 6 cycles, avm_address=32'h4, single write_valid/write_done pulse the cycle after acceptance.
- Simultaneous requests: both held high three times in succession → service order texture, write, texture; never both avm commands at once.
- Reset mid-read: rst asserted in RD_DATA → next cycle all outputs 0, busy=0; a later readdatavalid is ignored and texture_valid stays 0.
- Timeout (macro on, TIMEOUT_CYCLES=16): readdatavalid never asserted → texture_valid with 32'hDEAD_BEEF 16 cycles after command; timeout_err=1 and stays 1.
- Release rule: read_done pulse while texture_req stays high for 4 more cycles → FSM remains in RD_REL, only one avm_read total.
